serial_add_sched: RTL and testbench

Two-port scheduler for a shared bit-serial adder. The block arbitrates round-robin between two requesters and latches the granted requester's operands. It drives a single full-adder/carry-flop slice LSB-first for `W` cycles, then returns the `W+1`-bit sum with a one-hot done pulse. It sits between requesting datapath units and the single serial adder resource in the example designs.

---
 rtl/serial_add_pkg.sv | 24 ++
 rtl/serial_add_sched_if.sv | 33 +++
 rtl/serial_fa_bit.sv | 36 +++
 rtl/serial_add_sched.sv | 121 ++++++++++++
 tb/tb_serial_add_sched.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types and helpers for the bit-serial adder scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic req_idx_t;

    // Bit-counter width for a W-bit operand; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sched_if
// Purpose  : Requester-side bus of the serial adder scheduler.
//            Carries the sub select only when SERIAL_ADD_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_sched_if #(
    parameter int W = 8
);
    logic [1:0]   req;
    logic [W-1:0] a_0;
    logic [W-1:0] b_0;
    logic [W-1:0] a_1;
    logic [W-1:0] b_1;
`ifdef SERIAL_ADD_SUB_EN
    logic [1:0]   sub;
`endif
    logic [1:0]   ack;
    logic [1:0]   done;
    logic [W:0]   result;
    logic         busy;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output req, a_0, b_0, a_1, b_1, sub, input ack, done, result, busy);
    modport slave  (input  req, a_0, b_0, a_1, b_1, sub, output ack, done, result, busy);
`else
    modport master (output req, a_0, b_0, a_1, b_1, input ack, done, result, busy);
    modport slave  (input  req, a_0, b_0, a_1, b_1, output ack, done, result, busy);
`endif

endinterface
`default_nettype wire

// File: rtl/serial_fa_bit.sv
`default_nettype none
// ============================================================================
// Module   : serial_fa_bit
// Purpose  : One full-adder slice with its carry flop for LSB-first addition.
// Revision : 1.0 - initial release
// ============================================================================
module serial_fa_bit (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic a,
    input  wire logic b,
    input  wire logic clr,
    input  wire logic preset,
    input  wire logic en,
    output logic      sum,
    output logic      carry_next
);
    logic r_carry;

    assign sum        = a ^ b ^ r_carry;
    assign carry_next = (a & b) | (a & r_carry) | (b & r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (clr) begin
            r_carry <= 1'b0;
        end else if (preset) begin
            r_carry <= 1'b1;
        end else if (en) begin
            r_carry <= carry_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sched
// Purpose  : Round-robin two-port scheduler driving one bit-serial adder slice.
//            Define SERIAL_ADD_SUB_EN to add per-requester subtraction.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int W = 8
) (
    input wire logic          clk,
    input wire logic          rst_n,
    serial_add_sched_if.slave bus
);
    localparam int unsigned C_CNT_W = cnt_width(W);

    state_t               r_state;
    state_t               w_state_next;
    req_idx_t             r_grant;
    req_idx_t             r_last;
    req_idx_t             w_pick;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [W-1:0]         r_sum;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [W:0]           r_result;
    logic [W-1:0]         w_a_sel;
    logic [W-1:0]         w_b_sel;
    logic                 w_sub_sel;
    logic                 w_last_bit;
    logic                 w_sum_bit;
    logic                 w_carry_next;

    // A lone request wins outright; a tie goes to whoever was not served last.
    assign w_pick     = (bus.req == 2'b11) ? ~r_last : bus.req[1];
    assign w_a_sel    = r_grant ? bus.a_1 : bus.a_0;
    assign w_b_sel    = r_grant ? bus.b_1 : bus.b_0;
    assign w_last_bit = (r_cnt == C_CNT_W'(W - 1));

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub_sel = bus.sub[r_grant];
`else
    assign w_sub_sel = 1'b0;
`endif

    serial_fa_bit u_fa (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (r_a[0]),
        .b          (r_b[0]),
        .clr        ((r_state == LOAD) && !w_sub_sel),
        .preset     ((r_state == LOAD) && w_sub_sel),
        .en         (r_state == SHIFT),
        .sum        (w_sum_bit),
        .carry_next (w_carry_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.ack      = 2'b00;
        bus.done     = 2'b00;
        bus.busy     = (r_state != IDLE);
        bus.result   = r_result;
        unique case (r_state)
            IDLE:  if (|bus.req) w_state_next = LOAD;
            LOAD:  begin
                w_state_next = SHIFT;
                bus.ack      = 2'b01 << r_grant;
            end
            SHIFT: if (w_last_bit) w_state_next = DONE;
            DONE:  begin
                w_state_next = IDLE;
                bus.done     = 2'b01 << r_grant;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (|bus.req) r_grant <= w_pick;
                LOAD: begin
                    r_a    <= w_a_sel;
                    r_b    <= w_sub_sel ? ~w_b_sel : w_b_sel;
                    r_cnt  <= '0;
                    r_last <= r_grant;
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_sum <= {w_sum_bit, r_sum[W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    // Capture on the final bit so result is already valid while done pulses.
                    if (w_last_bit) r_result <= {w_carry_next, w_sum_bit, r_sum[W-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sched
// Purpose  : Directed table-driven bench for serial_add_sched (W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sched;

    typedef struct {
        logic [1:0] req;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [7:0] a1;
        logic [7:0] b1;
        logic [1:0] sub;
        int         g;
        logic [8:0] res;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t vecs[$];

    serial_add_sched_if #(.W(8)) bus ();

    serial_add_sched #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("ack_done_exclusive", {31'd0, (bus.ack != 2'b00) && (bus.done != 2'b00)}, 32'd0);
    endtask

    task automatic run_job(input vec_t v);
        int lat;
        bit got;
        bit busy_ok;
        bus.req = v.req;
        bus.a_0 = v.a0;
        bus.b_0 = v.b0;
        bus.a_1 = v.a1;
        bus.b_1 = v.b1;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = v.sub;
`endif
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (bus.ack != 2'b00) got = 1'b1;
        end
        chk("ack_onehot", {30'd0, bus.ack}, 32'd1 << v.g);
        busy_ok = bus.busy;
        // Operands must survive until the load edge, then become don't-care.
        step();
        busy_ok = busy_ok && bus.busy;
        bus.req = 2'b00;
        bus.a_0 = 8'($urandom);
        bus.b_0 = 8'($urandom);
        bus.a_1 = 8'($urandom);
        bus.b_1 = 8'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = 2'($urandom);
`endif
        lat = 1;
        while (lat < 30 && bus.done == 2'b00) begin
            step();
            lat++;
            busy_ok = busy_ok && bus.busy;
        end
        chk("done_latency", lat, 32'd9);
        chk("done_onehot", {30'd0, bus.done}, 32'd1 << v.g);
        chk("result", {23'd0, bus.result}, {23'd0, v.res});
        chk("busy_during_job", {31'd0, busy_ok}, 32'd1);
        step();
        chk("busy_after_job", {31'd0, bus.busy}, 32'd0);
        chk("result_hold", {23'd0, bus.result}, {23'd0, v.res});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        bit   done_seen;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req  = 2'b00;
        bus.a_0  = '0;
        bus.b_0  = '0;
        bus.a_1  = '0;
        bus.b_1  = '0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub  = 2'b00;
`endif
        //                req    a0   b0   a1   b1   sub  g  res
        vecs.push_back('{2'b01, 128, 128,   0,   0, 2'b00, 0, 9'd256});
        vecs.push_back('{2'b10,   0,   0, 255, 255, 2'b00, 1, 9'd510});
        vecs.push_back('{2'b11,   3,   4,  10,  20, 2'b00, 0, 9'd7});
        vecs.push_back('{2'b10,   0,   0,  10,  20, 2'b00, 1, 9'd30});
        vecs.push_back('{2'b11,   1,   2, 100,  27, 2'b00, 0, 9'd3});
        vecs.push_back('{2'b11,   1,   2, 100,  27, 2'b00, 1, 9'd127});
        vecs.push_back('{2'b11,  50,  60,   1,   1, 2'b00, 0, 9'd110});
        vecs.push_back('{2'b11,  50,  60, 200, 100, 2'b00, 1, 9'd300});
        vecs.push_back('{2'b01,   0,   0,   7,   7, 2'b00, 0, 9'd0});
        vecs.push_back('{2'b10,   9,   9, 255,   1, 2'b00, 1, 9'd256});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{2'b01,   5,   7,   0,   0, 2'b01, 0, 9'd254});
        vecs.push_back('{2'b10,   0,   0,   7,   5, 2'b10, 1, 9'd258});
`endif

        #2;
        chk("reset_ack",    {30'd0, bus.ack},    32'd0);
        chk("reset_done",   {30'd0, bus.done},   32'd0);
        chk("reset_result", {23'd0, bus.result}, 32'd0);
        chk("reset_busy",   {31'd0, bus.busy},   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_job(vecs[i]);

        // Reset in the middle of SHIFT aborts the job with no done.
        bus.req = 2'b01;
        bus.a_0 = 8'd5;
        bus.b_0 = 8'd6;
        for (int i = 0; i < 20 && bus.ack == 2'b00; i++) step();
        chk("midrst_ack", {30'd0, bus.ack}, 32'd1);
        repeat (5) step();
        bus.req = 2'b00;
        rst_n   = 1'b0;
        #1;
        chk("midrst_ack_clr",    {30'd0, bus.ack},    32'd0);
        chk("midrst_done_clr",   {30'd0, bus.done},   32'd0);
        chk("midrst_result_clr", {23'd0, bus.result}, 32'd0);
        chk("midrst_busy_clr",   {31'd0, bus.busy},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.done != 2'b00) done_seen = 1'b1;
        end
        chk("midrst_no_done", {31'd0, done_seen}, 32'd0);

        // Pointer is back at its reset value: requester 0 wins the tie.
        v = '{2'b11, 9, 9, 1, 1, 2'b00, 0, 9'd18};
        run_job(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
